// File: rtl/riscv_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : riscv_defs (package)
//  Purpose : Constants shared by the fetch/decode slice: RV32I opcodes,
//            instruction-class encodings and the fetch-fault marker word.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package riscv_defs;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Instruction classes presented to issue/execute
    typedef enum logic [2:0] {
        CLASS_ALU     = 3'd0,
        CLASS_LOAD    = 3'd1,
        CLASS_STORE   = 3'd2,
        CLASS_BRANCH  = 3'd3,
        CLASS_JUMP    = 3'd4,
        CLASS_MULDIV  = 3'd5,
        CLASS_CSR     = 3'd6,
        CLASS_INVALID = 3'd7
    } instr_class_e;

    // Word injected by fetch in place of an instruction when the fetch faulted
    localparam logic [31:0] INST_FAULT = 32'h0000_0053;

endpackage : riscv_defs
`default_nettype wire

// File: rtl/riscv_decode_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : riscv_decode_fifo
//  Purpose : 2-entry, 64-bit FIFO holding {instr, pc} pairs between fetch
//            and decode. Flush empties the FIFO without clearing storage.
//  Ports   : clk_i, rst_i (async, active-high)
//            push, pop, flush   - control (flush has priority over both)
//            wr_data[63:0]      - entry written on push
//            rd_data[63:0]      - current head entry
//            count[1:0]         - number of valid entries (0..2)
//  Rev     : 1.0  initial release
// ============================================================================
module riscv_decode_fifo (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [63:0] wr_data,
    output logic [63:0] rd_data,
    output logic [1:0]  count
);

    logic [63:0] r_mem0;
    logic [63:0] r_mem1;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    // Guard against over/underflow so the count can never leave 0..2.
    logic w_push;
    logic w_pop;
    assign w_push = push && (r_count != 2'd2);
    assign w_pop  = pop  && (r_count != 2'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem0   <= 64'd0;
            r_mem1   <= 64'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                if (r_wr_ptr) r_mem1 <= wr_data;
                else          r_mem0 <= wr_data;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign rd_data = r_rd_ptr ? r_mem1 : r_mem0;
    assign count   = r_count;

endmodule : riscv_decode_fifo
`default_nettype wire

// File: rtl/riscv_decode.sv
`default_nettype none
// ============================================================================
//  Module  : riscv_decode
//  Purpose : Decode stage. Buffers fetched {instr, pc} pairs in a 2-entry
//            FIFO and decodes the head entry into RV32I(M) fields.
//  Ports   : clk_i, rst_i (async, active-high)
//            fetch_valid_i/fetch_instr_i/fetch_pc_i/fetch_accept_o - fetch side
//            squash_i        - flush all buffered instructions
//            out_valid_o/out_accept_i - issue handshake
//            out_instr_o, out_pc_o, out_rd_idx_o, out_ra_idx_o, out_rb_idx_o,
//            out_imm_o, out_class_o, out_fault_o, out_illegal_o - head decode
//  Rev     : 1.0  initial release
// ============================================================================
module riscv_decode
    import riscv_defs::*;
#(
    parameter bit SUPPORT_MULDIV = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_instr_i,
    input  logic [31:0] fetch_pc_i,
    output logic        fetch_accept_o,
    input  logic        squash_i,
    output logic        out_valid_o,
    input  logic        out_accept_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic [4:0]  out_rd_idx_o,
    output logic [4:0]  out_ra_idx_o,
    output logic [4:0]  out_rb_idx_o,
    output logic [31:0] out_imm_o,
    output logic [2:0]  out_class_o,
    output logic        out_fault_o,
    output logic        out_illegal_o
);

    // ------------------------------------------------------------------
    // Buffer
    // ------------------------------------------------------------------
    logic [63:0] w_head;
    logic [1:0]  w_count;
    logic        w_push;
    logic        w_pop;

    // Accept depends only on the registered count: no bypass from a pop.
    assign fetch_accept_o = (w_count != 2'd2);
    assign out_valid_o    = (w_count != 2'd0);
    assign w_push         = fetch_valid_i && fetch_accept_o && !squash_i;
    assign w_pop          = out_valid_o && out_accept_i && !squash_i;

    riscv_decode_fifo u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (squash_i),
        .wr_data ({fetch_instr_i, fetch_pc_i}),
        .rd_data (w_head),
        .count   (w_count)
    );

    logic [31:0] w_instr;
    assign w_instr     = w_head[63:32];
    assign out_instr_o = w_instr;
    assign out_pc_o    = w_head[31:0];

    // ------------------------------------------------------------------
    // Decoder
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    assign w_opcode = w_instr[6:0];
    assign w_f3     = w_instr[14:12];
    assign w_f7     = w_instr[31:25];

    // Immediate formats; instr[31] is the sign bit in every one of them.
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                      w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'd0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                      w_instr[20], w_instr[30:21], 1'b0};

    logic         w_fault;
    instr_class_e w_class;
    logic         w_use_rd;
    logic         w_use_ra;
    logic         w_use_rb;
    logic [31:0]  w_imm;

    assign w_fault = (w_instr == INST_FAULT);

    always_comb begin
        w_class  = CLASS_INVALID;
        w_use_rd = 1'b0;
        w_use_ra = 1'b0;
        w_use_rb = 1'b0;
        w_imm    = 32'd0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_class  = CLASS_ALU;
                w_use_rd = 1'b1;
                w_imm    = w_imm_u;
            end
            OPC_JAL: begin
                w_class  = CLASS_JUMP;
                w_use_rd = 1'b1;
                w_imm    = w_imm_j;
            end
            OPC_JALR: begin
                if (w_f3 == 3'd0) begin
                    w_class  = CLASS_JUMP;
                    w_use_rd = 1'b1;
                    w_use_ra = 1'b1;
                    w_imm    = w_imm_i;
                end
            end
            OPC_BRANCH: begin
                if (w_f3 != 3'd2 && w_f3 != 3'd3) begin
                    w_class  = CLASS_BRANCH;
                    w_use_ra = 1'b1;
                    w_use_rb = 1'b1;
                    w_imm    = w_imm_b;
                end
            end
            OPC_LOAD: begin
                if (w_f3 != 3'd3 && w_f3 != 3'd6 && w_f3 != 3'd7) begin
                    w_class  = CLASS_LOAD;
                    w_use_rd = 1'b1;
                    w_use_ra = 1'b1;
                    w_imm    = w_imm_i;
                end
            end
            OPC_STORE: begin
                if (w_f3 <= 3'd2) begin
                    w_class  = CLASS_STORE;
                    w_use_ra = 1'b1;
                    w_use_rb = 1'b1;
                    w_imm    = w_imm_s;
                end
            end
            OPC_OP_IMM: begin
                // Shift-immediates carry funct7 in the upper immediate bits.
                if ((w_f3 == 3'd1 && w_f7 == FUNCT7_BASE) ||
                    (w_f3 == 3'd5 && (w_f7 == FUNCT7_BASE || w_f7 == FUNCT7_ALT)) ||
                    (w_f3 != 3'd1 && w_f3 != 3'd5)) begin
                    w_class  = CLASS_ALU;
                    w_use_rd = 1'b1;
                    w_use_ra = 1'b1;
                    w_imm    = w_imm_i;
                end
            end
            OPC_OP: begin
                if (w_f7 == FUNCT7_BASE ||
                    (w_f7 == FUNCT7_ALT && (w_f3 == 3'd0 || w_f3 == 3'd5))) begin
                    w_class = CLASS_ALU;
                end else if (w_f7 == FUNCT7_MULDIV && SUPPORT_MULDIV) begin
                    w_class = CLASS_MULDIV;
                end
                if (w_class != CLASS_INVALID) begin
                    w_use_rd = 1'b1;
                    w_use_ra = 1'b1;
                    w_use_rb = 1'b1;
                end
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                w_class  = CLASS_CSR;
                w_use_rd = 1'b1;
                w_use_ra = 1'b1;
                w_imm    = w_imm_i;
            end
            default: begin
                w_class = CLASS_INVALID;
            end
        endcase
    end

    // The fault marker's opcode is not in the decoded set, so it already
    // lands in CLASS_INVALID with all fields zero; only the flags differ.
    assign out_class_o   = w_class;
    assign out_fault_o   = w_fault;
    assign out_illegal_o = (w_class == CLASS_INVALID) && !w_fault;
    assign out_rd_idx_o  = w_use_rd ? w_instr[11:7]  : 5'd0;
    assign out_ra_idx_o  = w_use_ra ? w_instr[19:15] : 5'd0;
    assign out_rb_idx_o  = w_use_rb ? w_instr[24:20] : 5'd0;
    assign out_imm_o     = w_imm;

endmodule : riscv_decode
`default_nettype wire

// File: tb/tb_riscv_decode.sv
`default_nettype none
// ============================================================================
//  Module  : tb_riscv_decode
//  Purpose : Scoreboard bench for riscv_decode. Two instances share stimulus:
//            u_dut (SUPPORT_MULDIV=1) and u_dut_nomd (SUPPORT_MULDIV=0).
//            A negedge monitor keeps a FIFO model of expected entries and
//            compares the head outputs every cycle.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_riscv_decode;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] imm;
        logic [2:0]  cls;
        logic        fault;
        logic        ill;
        logic [2:0]  cls0;   // class expected from the SUPPORT_MULDIV=0 copy
        logic        ill0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        squash;
    logic        out_accept;

    logic        fetch_accept_o, out_valid_o, out_fault_o, out_illegal_o;
    logic [31:0] out_instr_o, out_pc_o, out_imm_o;
    logic [4:0]  out_rd_idx_o, out_ra_idx_o, out_rb_idx_o;
    logic [2:0]  out_class_o;

    logic        n_fetch_accept, n_out_valid, n_fault, n_illegal;
    logic [31:0] n_instr, n_pc, n_imm;
    logic [4:0]  n_rd, n_ra, n_rb;
    logic [2:0]  n_class;

    always #5 clk = ~clk;

    riscv_decode #(.SUPPORT_MULDIV(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .fetch_valid_i(fetch_valid), .fetch_instr_i(fetch_instr),
        .fetch_pc_i(fetch_pc), .fetch_accept_o(fetch_accept_o),
        .squash_i(squash), .out_valid_o(out_valid_o), .out_accept_i(out_accept),
        .out_instr_o(out_instr_o), .out_pc_o(out_pc_o),
        .out_rd_idx_o(out_rd_idx_o), .out_ra_idx_o(out_ra_idx_o),
        .out_rb_idx_o(out_rb_idx_o), .out_imm_o(out_imm_o),
        .out_class_o(out_class_o), .out_fault_o(out_fault_o),
        .out_illegal_o(out_illegal_o)
    );

    riscv_decode #(.SUPPORT_MULDIV(1'b0)) u_dut_nomd (
        .clk_i(clk), .rst_i(rst_i),
        .fetch_valid_i(fetch_valid), .fetch_instr_i(fetch_instr),
        .fetch_pc_i(fetch_pc), .fetch_accept_o(n_fetch_accept),
        .squash_i(squash), .out_valid_o(n_out_valid), .out_accept_i(out_accept),
        .out_instr_o(n_instr), .out_pc_o(n_pc),
        .out_rd_idx_o(n_rd), .out_ra_idx_o(n_ra),
        .out_rb_idx_o(n_rb), .out_imm_o(n_imm),
        .out_class_o(n_class), .out_fault_o(n_fault),
        .out_illegal_o(n_illegal)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   stim_timeouts = 0;
    logic done = 1'b0;
    logic model_pushed = 1'b0;
    exp_t cur_exp;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [4:0] rd, input logic [4:0] ra,
                                input logic [4:0] rb, input logic [31:0] imm,
                                input logic [2:0] cls, input logic fault,
                                input logic ill, input logic [2:0] cls0,
                                input logic ill0);
        exp_t e;
        e.instr = instr; e.pc = pc; e.rd = rd; e.ra = ra; e.rb = rb;
        e.imm = imm; e.cls = cls; e.fault = fault; e.ill = ill;
        e.cls0 = cls0; e.ill0 = ill0;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard (negedge, away from the active edge)
    // ------------------------------------------------------------------
    initial begin
        int  cycles;
        bit  do_push, do_pop;
        exp_t h;
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (done || cycles > 3000) begin
                if (!done) $display("FAIL watchdog: bench did not complete in %0d cycles", cycles);
                chk("stim_timeouts", stim_timeouts, 0);
                chk("watchdog", {31'd0, done}, 32'd1);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
            if (rst_i) begin
                sb.delete();
                model_pushed = 1'b0;
                chk("rst_accept", {31'd0, fetch_accept_o}, 32'd1);
                chk("rst_valid",  {31'd0, out_valid_o},    32'd0);
                chk("rst_instr",  out_instr_o, 32'd0);
                chk("rst_pc",     out_pc_o,    32'd0);
            end else begin
                chk("fetch_accept", {31'd0, fetch_accept_o}, {31'd0, sb.size() != 2});
                chk("out_valid",    {31'd0, out_valid_o},    {31'd0, sb.size() != 0});
                chk("nomd_valid",   {31'd0, n_out_valid},    {31'd0, sb.size() != 0});
                if (sb.size() != 0) begin
                    h = sb[0];
                    chk("instr",   out_instr_o, h.instr);
                    chk("pc",      out_pc_o,    h.pc);
                    chk("rd",      {27'd0, out_rd_idx_o}, {27'd0, h.rd});
                    chk("ra",      {27'd0, out_ra_idx_o}, {27'd0, h.ra});
                    chk("rb",      {27'd0, out_rb_idx_o}, {27'd0, h.rb});
                    chk("imm",     out_imm_o,   h.imm);
                    chk("class",   {29'd0, out_class_o}, {29'd0, h.cls});
                    chk("fault",   {31'd0, out_fault_o},   {31'd0, h.fault});
                    chk("illegal", {31'd0, out_illegal_o}, {31'd0, h.ill});
                    chk("nomd_class",   {29'd0, n_class},   {29'd0, h.cls0});
                    chk("nomd_illegal", {31'd0, n_illegal}, {31'd0, h.ill0});
                end
                // Predict the effect of the coming edge.
                model_pushed = 1'b0;
                if (squash) begin
                    sb.delete();
                end else begin
                    do_pop  = (sb.size() != 0) && out_accept;
                    do_push = fetch_valid && (sb.size() != 2);
                    if (do_pop)  void'(sb.pop_front());
                    if (do_push) begin
                        sb.push_back(cur_exp);
                        model_pushed = 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input exp_t e, input int max_wait);
        bit ok;
        ok = 1'b0;
        fetch_valid = 1'b1;
        fetch_instr = e.instr;
        fetch_pc    = e.pc;
        cur_exp     = e;
        for (int i = 0; i < max_wait; i++) begin
            step();
            if (model_pushed) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            stim_timeouts++;
            $display("FAIL send_timeout: pc %h not accepted within %0d cycles", e.pc, max_wait);
        end
        fetch_valid = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; fetch_valid = 1'b0; fetch_instr = 32'd0; fetch_pc = 32'd0;
        squash = 1'b0; out_accept = 1'b0;
        cur_exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        rst_i = 1'b0;
        step();

        // addi x1,x0,5 : held one idle cycle, then popped
        send(mk(32'h00500093, 32'h0, 1, 0, 0, 32'd5, 3'd0, 0, 0, 3'd0, 0), 2);
        step();
        out_accept = 1'b1;
        step();
        out_accept = 1'b0;
        step();

        // Three pushes against a stalled consumer; third waits for a pop
        send(mk(32'h00812283, 32'h0, 5, 2, 0, 32'd8, 3'd1, 0, 0, 3'd1, 0), 2);
        send(mk(32'hFE612E23, 32'h4, 0, 2, 6, 32'hFFFFFFFC, 3'd2, 0, 0, 3'd2, 0), 2);
        fork
            send(mk(32'h4030D093, 32'h8, 1, 1, 0, 32'h403, 3'd0, 0, 0, 3'd0, 0), 10);
            begin
                repeat (3) step();
                out_accept = 1'b1;
            end
        join
        repeat (3) step();
        out_accept = 1'b0;

        // Fill, then squash together with a push attempt
        send(mk(32'h123451B7, 32'h100, 3, 0, 0, 32'h12345000, 3'd0, 0, 0, 3'd0, 0), 2);
        send(mk(32'h010000EF, 32'h104, 1, 0, 0, 32'd16, 3'd4, 0, 0, 3'd4, 0), 2);
        fetch_valid = 1'b1; fetch_instr = 32'hFFFFFFFF; fetch_pc = 32'h108;
        squash = 1'b1;
        step();
        squash = 1'b0; fetch_valid = 1'b0;
        step();

        // Back-to-back stream with consumer always ready: one per cycle
        out_accept = 1'b1;
        send(mk(32'h00000053, 32'h200, 0, 0, 0, 32'd0, 3'd7, 1, 0, 3'd7, 0), 1);
        send(mk(32'hFE000EE3, 32'h204, 0, 0, 0, 32'hFFFFFFFC, 3'd3, 0, 0, 3'd3, 0), 1);
        send(mk(32'h02208033, 32'h208, 0, 1, 2, 32'd0, 3'd5, 0, 0, 3'd7, 1), 1);
        send(mk(32'hFFFFFFFF, 32'h20C, 0, 0, 0, 32'd0, 3'd7, 0, 1, 3'd7, 1), 1);
        send(mk(32'h00002063, 32'h210, 0, 0, 0, 32'd0, 3'd7, 0, 1, 3'd7, 1), 1);
        send(mk(32'h00000073, 32'h214, 0, 0, 0, 32'd0, 3'd6, 0, 0, 3'd6, 0), 1);
        step();
        out_accept = 1'b0;

        // Asynchronous reset with two entries buffered, asserted between edges
        send(mk(32'h00500093, 32'h300, 1, 0, 0, 32'd5, 3'd0, 0, 0, 3'd0, 0), 2);
        send(mk(32'h00812283, 32'h304, 5, 2, 0, 32'd8, 3'd1, 0, 0, 3'd1, 0), 2);
        #2;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        repeat (2) step();
        done = 1'b1;
    end

endmodule : tb_riscv_decode
`default_nettype wire

// File: doc/riscv_decode.md
# riscv_decode

Decode stage sitting directly downstream of `riscv_fetch`. It buffers fetched instruction/PC pairs in a 2-entry FIFO, applies back-pressure to fetch via `fetch_accept_o`, and presents the FIFO head to issue/execute with RV32I(M) decode fields: register indices, sign-extended immediate, instruction class and fault/illegal flags. A squash input from execute discards all buffered instructions on a taken branch.

## Interface
- `SUPPORT_MULDIV`, default 1: decode the RV32M ops (OP opcode, funct7=0000001) as class MULDIV. When 0, they are illegal.
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `fetch_valid_i`  in  1  fetch holds a valid instruction
- `fetch_instr_i`  in  32  instruction word
- `fetch_pc_i`  in  32  PC of the instruction
- `fetch_accept_o`  out  1  decode takes the instruction this cycle
- `squash_i`  in  1  taken branch/redirect: flush all buffered instructions
- `out_valid_o`  out  1  head entry valid
- `out_accept_i`  in  1  issue consumes the head this cycle
- `out_instr_o`  out  32  raw instruction at the head
- `out_pc_o`  out  32  PC at the head
- `out_rd_idx_o`, `out_ra_idx_o`, `out_rb_idx_o`  out  5 each  rd/rs1/rs2 fields. Forced to 0 when the format lacks that field.
- `out_imm_o`  out  32  sign-extended immediate (I/S/B/U/J). 0 for R-type.
- `out_class_o`  out  3  0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 MULDIV, 6 CSR/SYSTEM, 7 INVALID
- `out_fault_o`  out  1  head is the fetch-fault marker (instr == INST_FAULT, 32'h53)
- `out_illegal_o`  out  1  head opcode/funct not in the supported set. Never set together with `out_fault_o`.

## Operation
- FIFO state:
  - 2 entries, each holding instr[31:0] and pc[31:0].
  - Write pointer, read pointer (1 bit each) and a count (0..2).
- `fetch_accept_o = (count != 2)`. Combinational from the registered count. There is no dependency on `out_accept_i`, and no bypass.
- Push condition: `fetch_valid_i && fetch_accept_o && !squash_i`.
- Pop condition: `out_valid_o && out_accept_i && !squash_i`.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- `out_valid_o = (count != 0)`. All `out_*` decode fields are combinational from the head entry.
- Squash:
  - On an edge with `squash_i=1`: count←0 and pointers←0.
  - A push or pop requested in that cycle is ignored.
  - Entry data is not cleared.
- Class/illegal decode:
  - Opcodes LUI and AUIPC, plus OP-IMM/OP with valid funct3/funct7, → ALU.
  - LOAD with funct3 ∈ {0,1,2,4,5} → LOAD.
  - STORE with funct3 ∈ {0,1,2} → STORE.
  - BRANCH with funct3 ∉ {2,3} → BRANCH.
  - JAL, and JALR with funct3=0 → JUMP.
  - SYSTEM and MISC-MEM → CSR.
  - Anything else → INVALID, with `out_illegal_o=1`.
- Fault marker:
  - INST_FAULT → class INVALID, `out_fault_o=1`, `out_illegal_o=0`.
  - Index fields 0, immediate 0.
- Immediates: every format uses instr[31] as the sign. Arithmetic is 32-bit; there is no width growth.

## Timing
- Reset:
  - count=0, pointers=0, entry storage=0.
  - Outputs: `fetch_accept_o=1`, `out_valid_o=0`, `out_instr_o=0`, `out_pc_o=0`.
- Latency: an instruction pushed at edge N is visible at the head (`out_valid_o=1`) in the cycle after edge N. No sooner, even if the FIFO was empty.
- Throughput: 1 instruction/cycle sustained when `out_accept_i` is held at 1.
- Full (count=2):
  - `fetch_accept_o=0`, even if a pop occurs that cycle.
  - Accept returns the cycle after the pop edge.
- Empty: `out_accept_i` is ignored.
- Decode outputs hold stable while `out_valid_o && !out_accept_i`.
- Squash during a push with count=2: push is dropped anyway; FIFO is empty after the edge.
- Reset mid-operation clears state immediately (asynchronous). Buffered instructions are lost.

## Structure
- Shared package `riscv_defs`:
  - Opcode constants.
  - Class encodings (CLASS_ALU..CLASS_INVALID).
  - INST_FAULT (32'h53), shared with fetch.
- Sub-module `riscv_decode_fifo`: 2-entry, 64-bit-wide FIFO with push/pop/flush and count.
- The top level holds only the combinational decoder.

## Test plan
- Reset, then push instr 32'h00500093 (addi x1,x0,5) at pc 0x0 → next cycle:
  - `out_valid_o=1`, class ALU, rd=1, ra=0, imm=5.
  - Pop → `out_valid_o=0`.
- Hold `out_accept_i=0` and push 3 instructions → the third stalls with `fetch_accept_o=0` and count=2. Release accept → order is preserved (pc 0x0, 0x4, 0x8).
- Count=2, assert `squash_i` together with `fetch_valid_i` → the next cycle has `out_valid_o=0` and `fetch_accept_o=1`. The squashed instruction is never seen.
- Push 32'h53 → `out_fault_o=1`, class INVALID, `out_illegal_o=0`.
- Push 32'hFE000EE3 (beq x0,x0,-4) → class BRANCH, imm 32'hFFFFFFFC.
- Push 32'h02208033 (mul) with SUPPORT_MULDIV=0 → `out_illegal_o=1`. With SUPPORT_MULDIV=1 → class MULDIV.
